imem_loadable: RTL and testbench

- Parametrised, synchronous instruction memory for the pipelined MIPS core's IF stage.
- Registered read with stall hold.
- Word-serial program-load port with valid/ready handshake, replacing hard-wired ROM contents.
- Per-word "loaded" tracking, so unloaded or out-of-range fetches return a defined NOP plus a fault flag instead of X.

---
 rtl/pipeline_pkg.sv | 11 +
 rtl/imem_array.sv | 43 ++++
 rtl/imem_loadable.sv | 119 +++++++++++
 tb/tb_imem_loadable.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared IF-stage definitions: the fetch NOP word and the instruction-memory load FSM encoding.
package pipeline_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;  // sll $0,$0,0

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } imem_state_t;

endpackage

// File: rtl/imem_array.sv
// DEPTH x WORD_W storage: sync write, sync read (1 cycle, held when rd_en=0), per-word loaded bits.
// The loaded vector has async reset and bulk clear; the data array itself is never reset.
module imem_array #(
  parameter int DEPTH_LOG2 = 5,
  parameter int WORD_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    wr_en,
  input  logic [DEPTH_LOG2-1:0]   wr_idx,
  input  logic [WORD_W-1:0]       wr_dat,
  input  logic                    rd_en,
  input  logic [DEPTH_LOG2-1:0]   rd_idx,
  output logic [WORD_W-1:0]       rd_dat,
  output logic [2**DEPTH_LOG2-1:0] loaded
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_dat;
    end
    if (rd_en) begin
      rd_dat <= mem[rd_idx];
    end
  end

  // Stale words stay in mem after a clear; these bits are what hide them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loaded <= '0;
    end else if (clr) begin
      loaded <= '0;
    end else if (wr_en) begin
      loaded[wr_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory: 1-cycle registered fetch held on Stall, faults read as NOP.
// Word-serial load port; LdReady high for the whole LOAD state, exit on LdLast or the final word.
module imem_loadable #(
  parameter int                DEPTH_LOG2 = 5,
  parameter int                WORD_W     = 32,
  parameter logic [WORD_W-1:0] NOP_WORD   = WORD_W'(pipeline_pkg::NOP_WORD)
) (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic [31:0]       Addr,
  input  logic              Stall,
  output logic [WORD_W-1:0] Inst,
  output logic              InstValid,
  output logic              AddrFault,
  input  logic              LdStart,
  input  logic [WORD_W-1:0] LdData,
  input  logic              LdValid,
  input  logic              LdLast,
  output logic              LdReady,
  output logic              LdDone,
  output logic              Busy
);

  import pipeline_pkg::*;

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  imem_state_t           state, state_nx;
  logic [DEPTH_LOG2-1:0] cnt;
  logic                  inst_vld_q, fault_q, done_q;
  logic                  wr_en, rd_en, clr, last_word;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [WORD_W-1:0]     rd_dat;
  logic [DEPTH-1:0]      loaded;
  logic                  fetch_fault;

  assign rd_idx = Addr[DEPTH_LOG2+1:2];

  assign fetch_fault = (Addr[1:0] != 2'b00)
                    || (Addr[31:DEPTH_LOG2+2] != '0)
                    || !loaded[rd_idx];

  imem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WORD_W     (WORD_W)
  ) u_array (
    .clk    (Clk),
    .rst_n  (Clrn),
    .clr    (clr),
    .wr_en  (wr_en),
    .wr_idx (cnt),
    .wr_dat (LdData),
    .rd_en  (rd_en),
    .rd_idx (rd_idx),
    .rd_dat (rd_dat),
    .loaded (loaded)
  );

  always_comb begin
    state_nx  = state;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    clr       = 1'b0;
    last_word = 1'b0;
    case (state)
      RUN: begin
        if (LdStart) begin
          state_nx = LOAD;
          clr      = 1'b1;
        end else if (!Stall) begin
          rd_en = 1'b1;
        end
      end
      LOAD: begin
        wr_en = LdValid;
        // The final slot ends the load even without LdLast, so cnt never wraps.
        if (LdValid && (LdLast || (&cnt))) begin
          last_word = 1'b1;
          state_nx  = RUN;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state      <= RUN;
      cnt        <= '0;
      inst_vld_q <= 1'b0;
      fault_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= last_word;
      if (clr) begin
        cnt <= '0;
      end else if (wr_en) begin
        cnt <= cnt + 1'b1;
      end
      if (clr) begin
        inst_vld_q <= 1'b0;
        fault_q    <= 1'b0;
      end else if (rd_en) begin
        inst_vld_q <= 1'b1;
        fault_q    <= fetch_fault;
      end
    end
  end

  // rd_dat is unreset and may hold a stale word; only a clean, valid fetch exposes it.
  assign Inst      = (inst_vld_q && !fault_q) ? rd_dat : NOP_WORD;
  assign InstValid = inst_vld_q;
  assign AddrFault = fault_q;
  assign LdReady   = (state == LOAD);
  assign Busy      = (state == LOAD);
  assign LdDone    = done_q;

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable: table-driven fetch vectors plus load, stall, reset and restart sequences.
module tb_imem_loadable;

  import pipeline_pkg::*;

  logic        Clk = 1'b0;
  logic        Clrn;
  logic [31:0] Addr;
  logic        Stall;
  logic [31:0] Inst;
  logic        InstValid;
  logic        AddrFault;
  logic        LdStart;
  logic [31:0] LdData;
  logic        LdValid;
  logic        LdLast;
  logic        LdReady;
  logic        LdDone;
  logic        Busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] addr;
    logic        stall;
    logic [31:0] inst;
    logic        vld;
    logic        flt;
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] ld_words [32];

  imem_loadable #(
    .DEPTH_LOG2 (5),
    .WORD_W     (32),
    .NOP_WORD   (32'h0000_0000)
  ) dut (
    .Clk       (Clk),
    .Clrn      (Clrn),
    .Addr      (Addr),
    .Stall     (Stall),
    .Inst      (Inst),
    .InstValid (InstValid),
    .AddrFault (AddrFault),
    .LdStart   (LdStart),
    .LdData    (LdData),
    .LdValid   (LdValid),
    .LdLast    (LdLast),
    .LdReady   (LdReady),
    .LdDone    (LdDone),
    .Busy      (Busy)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic fetch_chk(input string nm, input logic [31:0] a, input logic [31:0] inst,
                           input logic vld, input logic flt);
    Addr  = a;
    Stall = 1'b0;
    tick();
    chk({nm, "_inst"}, Inst, inst);
    chk({nm, "_vld"}, {31'd0, InstValid}, {31'd0, vld});
    chk({nm, "_flt"}, {31'd0, AddrFault}, {31'd0, flt});
  endtask

  // Drives a full load of ld_words[0..n-1]; gap inserts an idle cycle before every word.
  task automatic do_load(input string nm, input int n, input bit use_last, input bit gap);
    int   sent  = 0;
    int   cyc   = 0;
    int   dones = 0;
    logic xfer;
    LdStart = 1'b1;
    tick();
    LdStart = 1'b0;
    chk({nm, "_busy_in_load"}, {31'd0, Busy}, 32'd1);
    chk({nm, "_ready_in_load"}, {31'd0, LdReady}, 32'd1);
    chk({nm, "_ivalid_in_load"}, {31'd0, InstValid}, 32'd0);
    while (sent < n && cyc < 200) begin
      LdValid = gap ? (cyc % 2 == 0) : 1'b1;
      LdData  = ld_words[sent];
      LdLast  = use_last && (sent == n - 1);
      xfer    = LdValid && LdReady;
      tick();
      cyc++;
      if (xfer) sent++;
      if (LdDone) dones++;
    end
    LdValid = 1'b0;
    LdLast  = 1'b0;
    chk({nm, "_xfers"}, sent, n);
    chk({nm, "_done_after_last"}, {31'd0, LdDone}, 32'd1);
    chk({nm, "_busy_after"}, {31'd0, Busy}, 32'd0);
    chk({nm, "_ready_after"}, {31'd0, LdReady}, 32'd0);
    tick();
    if (LdDone) dones++;
    chk({nm, "_done_pulses"}, dones, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h04, 1'b0, 32'h3402000C, 1'b1, 1'b0};
    vecs[1] = '{32'h0C, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[2] = '{32'h06, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[3] = '{32'h80, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[4] = '{32'h08, 1'b0, 32'h00221820, 1'b1, 1'b0};
    vecs[5] = '{32'h00, 1'b1, 32'h00221820, 1'b1, 1'b0};
    vecs[6] = '{32'h00, 1'b1, 32'h00221820, 1'b1, 1'b0};
    vecs[7] = '{32'h00, 1'b1, 32'h00221820, 1'b1, 1'b0};
    vecs[8] = '{32'h00, 1'b0, 32'h20010008, 1'b1, 1'b0};

    Clrn    = 1'b0;
    Addr    = 32'h0;
    Stall   = 1'b0;
    LdStart = 1'b0;
    LdData  = 32'h0;
    LdValid = 1'b0;
    LdLast  = 1'b0;
    tick();
    tick();
    chk("rst_inst", Inst, NOP_WORD);
    chk("rst_vld", {31'd0, InstValid}, 32'd0);
    chk("rst_flt", {31'd0, AddrFault}, 32'd0);
    chk("rst_ready", {31'd0, LdReady}, 32'd0);
    chk("rst_done", {31'd0, LdDone}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    Clrn = 1'b1;
    tick();

    // Three-word program terminated by LdLast, then the fetch/fault/stall table.
    ld_words[0] = 32'h20010008;
    ld_words[1] = 32'h3402000C;
    ld_words[2] = 32'h00221820;
    do_load("ld3", 3, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      Addr  = vecs[i].addr;
      Stall = vecs[i].stall;
      tick();
      chk($sformatf("vec%0d_inst", i), Inst, vecs[i].inst);
      chk($sformatf("vec%0d_vld", i), {31'd0, InstValid}, {31'd0, vecs[i].vld});
      chk($sformatf("vec%0d_flt", i), {31'd0, AddrFault}, {31'd0, vecs[i].flt});
    end

    // Full depth, LdValid every other cycle, no LdLast: must auto-terminate at word 31.
    for (int i = 0; i < 32; i++) ld_words[i] = i;
    do_load("ld32", 32, 1'b0, 1'b1);
    fetch_chk("full_7c", 32'h7C, 32'd31, 1'b1, 1'b0);
    fetch_chk("full_40", 32'h40, 32'd16, 1'b1, 1'b0);
    fetch_chk("full_oob", 32'h7E, NOP_WORD, 1'b1, 1'b1);

    // Reset asserted asynchronously after two of five words.
    LdStart = 1'b1;
    tick();
    LdStart = 1'b0;
    LdValid = 1'b1;
    LdData  = 32'hAAAA0000;
    tick();
    LdData  = 32'hAAAA0001;
    tick();
    LdData  = 32'hAAAA0002;
    #3;
    Clrn = 1'b0;
    #1;
    chk("abort_vld", {31'd0, InstValid}, 32'd0);
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    chk("abort_ready", {31'd0, LdReady}, 32'd0);
    LdValid = 1'b0;
    #2;
    Clrn = 1'b1;
    tick();
    fetch_chk("abort_a0", 32'h00, NOP_WORD, 1'b1, 1'b1);
    fetch_chk("abort_a4", 32'h04, NOP_WORD, 1'b1, 1'b1);

    // LdStart during Stall still enters LOAD and invalidates the old program.
    ld_words[0] = 32'h20010008;
    ld_words[1] = 32'h3402000C;
    ld_words[2] = 32'h00221820;
    do_load("reload", 3, 1'b1, 1'b0);
    fetch_chk("reload_a4", 32'h04, 32'h3402000C, 1'b1, 1'b0);
    Stall   = 1'b1;
    LdStart = 1'b1;
    tick();
    LdStart = 1'b0;
    chk("stallstart_busy", {31'd0, Busy}, 32'd1);
    chk("stallstart_vld", {31'd0, InstValid}, 32'd0);
    chk("stallstart_inst", Inst, NOP_WORD);
    Stall   = 1'b0;
    LdValid = 1'b1;
    LdLast  = 1'b1;
    LdData  = 32'hDEADBEEF;
    tick();
    LdValid = 1'b0;
    LdLast  = 1'b0;
    chk("stallstart_done", {31'd0, LdDone}, 32'd1);
    fetch_chk("stallstart_a4", 32'h04, NOP_WORD, 1'b1, 1'b1);
    fetch_chk("stallstart_a0", 32'h00, 32'hDEADBEEF, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
